// File: rtl/led_pulse_stretcher.sv
// led_pulse_stretcher
//
// Turns single-cycle internal event strobes into pulses long enough to see on a
// board pin (LED or buzzer). Each event drives the pin high for WIDTH_CYC
// cycles and then low for at least GAP_CYC cycles. Strobes that arrive while a
// pulse or gap is in progress are counted and replayed in order. If the
// pending counter is full, the event is dropped and a sticky overflow flag is
// set.
//
// Parameters
//   WIDTH_CYC : high time of each pulse, in clk cycles (>= 1)
//   GAP_CYC   : minimum low time after each pulse, in clk cycles (>= 1)
//   CNT_W     : timer width; must hold max(WIDTH_CYC, GAP_CYC) - 1
//   PEND_W    : pending-counter width; saturates at 2^PEND_W - 1
//
// Ports
//   clk       : system clock, rising edge
//   rst       : asynchronous active-low reset
//   pulse_in  : event strobe; every high cycle counts as one event
//   clear     : synchronous flush of pending events and the overflow flag
//   led_out   : stretched pulse to the pin (registered)
//   busy      : high while a pulse or gap is in progress (registered)
//   pend_cnt  : queued events not yet emitted
//   overflow  : sticky; an event was dropped at saturation
module led_pulse_stretcher #(
  parameter int unsigned WIDTH_CYC = 16,
  parameter int unsigned GAP_CYC   = 8,
  parameter int unsigned CNT_W     = 24,
  parameter int unsigned PEND_W    = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pulse_in,
  input  logic              clear,
  output logic              led_out,
  output logic              busy,
  output logic [PEND_W-1:0] pend_cnt,
  output logic              overflow
);

  typedef enum logic [1:0] {
    StIdle,
    StHigh,
    StGap
  } state_e;

  localparam logic [CNT_W-1:0]  WidthLoad = CNT_W'(WIDTH_CYC - 1);
  localparam logic [CNT_W-1:0]  GapLoad   = CNT_W'(GAP_CYC - 1);
  localparam logic [PEND_W-1:0] PendMax   = '1;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  timer_q, timer_d;
  logic              led_q, led_d;
  logic              busy_q, busy_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic              ovf_q, ovf_d;

  logic strobe;
  logic timer_zero;
  logic gap_last;
  logic pend_nz;
  logic inc;
  logic dec;

  // clear masks the strobe in the same cycle, so a flushed cycle never queues
  // or launches anything.
  assign strobe     = pulse_in & ~clear;
  assign timer_zero = (timer_q == '0);
  assign gap_last   = (state_q == StGap) & timer_zero;
  assign pend_nz    = (pend_q != '0);

  // ---------------------------------------------------------------------------
  // Pulse sequencer
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    unique case (state_q)
      StIdle: begin
        if (strobe) begin
          state_d = StHigh;
          timer_d = WidthLoad;
        end
      end
      StHigh: begin
        if (timer_zero) begin
          state_d = StGap;
          timer_d = GapLoad;
        end else begin
          timer_d = timer_q - CNT_W'(1);
        end
      end
      StGap: begin
        if (timer_zero) begin
          // A clear in the last gap cycle flushes the queue, so the queued
          // events must not relaunch a pulse here either.
          if ((pend_nz & ~clear) | strobe) begin
            state_d = StHigh;
            timer_d = WidthLoad;
          end else begin
            state_d = StIdle;
          end
        end else begin
          timer_d = timer_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = StIdle;
        timer_d = '0;
      end
    endcase

    // Outputs are registered copies of the next state, so they change on the
    // same edge as the state transition.
    led_d  = (state_d == StHigh);
    busy_d = (state_d != StIdle);
  end

  // ---------------------------------------------------------------------------
  // Pending-event accounting
  // ---------------------------------------------------------------------------
  // A strobe in the last gap cycle with nothing queued launches the next pulse
  // directly, so it is not queued.
  assign inc = strobe & (state_q != StIdle) & ~(gap_last & ~pend_nz);
  assign dec = gap_last & pend_nz;

  always_comb begin
    pend_d = pend_q;
    ovf_d  = ovf_q;
    if (clear) begin
      pend_d = '0;
      ovf_d  = 1'b0;
    end else if (inc & ~dec) begin
      if (pend_q == PendMax) begin
        ovf_d = 1'b1;
      end else begin
        pend_d = pend_q + PEND_W'(1);
      end
    end else if (dec & ~inc) begin
      pend_d = pend_q - PEND_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      timer_q <= '0;
      led_q   <= 1'b0;
      busy_q  <= 1'b0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      led_q   <= led_d;
      busy_q  <= busy_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
    end
  end

  assign led_out  = led_q;
  assign busy     = busy_q;
  assign pend_cnt = pend_q;
  assign overflow = ovf_q;

endmodule

// File: doc/led_pulse_stretcher.md
Name: led_pulse_stretcher

Overview:
- Output-side counterpart of the pushbutton input conditioner: it turns internal single-cycle event strobes into externally visible pulses.
- Each strobe drives the board pin (LED/buzzer) high for a guaranteed minimum time, then low for a guaranteed minimum time.
- Strobes that arrive while a pulse or gap is in progress are counted and replayed in order, so no event is silently merged.
- Sits between control logic and the top-level output pin.

Parameters:
- WIDTH_CYC, 16, high time of each output pulse in clk cycles (>=1).
- GAP_CYC, 8, minimum low time after each pulse in clk cycles (>=1).
- CNT_W, 24, timer width; must hold max(WIDTH_CYC, GAP_CYC)-1.
- PEND_W, 3, pending-counter width; saturates at PMAX = 2^PEND_W-1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- pulse_in  in  1  event strobe; every cycle it is high counts as one event (no edge detection).
- clear  in  1  synchronous; flushes pending events and overflow.
- led_out  out  1  stretched pulse to pin; registered.
- busy  out  1  high whenever state != IDLE; registered.
- pend_cnt  out  PEND_W  queued events not yet emitted.
- overflow  out  1  sticky; an event was dropped at saturation.

Behaviour:
- Reset (rst=0, async, no clock needed):
  - led_out=0, busy=0, pend_cnt=0, overflow=0.
  - state=IDLE, timer=0.
- States: IDLE, HIGH, GAP.
- IDLE:
  - If pulse_in=1 and clear=0 at an edge: at that same edge go to HIGH, set led_out=1 and busy=1, load timer=WIDTH_CYC-1.
  - Latency is 1 edge.
- HIGH:
  - led_out=1 for exactly WIDTH_CYC cycles.
  - When timer==0: go to GAP, set led_out=0, load timer=GAP_CYC-1.
- GAP:
  - led_out=0 for exactly GAP_CYC cycles.
  - When timer==0, if pend_cnt>0 or (pulse_in=1 and clear=0): go to HIGH (led_out=1, timer=WIDTH_CYC-1).
  - Otherwise go to IDLE and set busy=0.
- Pending accounting, evaluated per edge:
  - inc = pulse_in & !clear & (state!=IDLE), excluding the final GAP cycle when pend_cnt==0 (that strobe launches HIGH directly).
  - dec = final GAP cycle with pend_cnt>0.
  - inc & dec: pend_cnt unchanged.
  - inc only: pend_cnt+1, saturating at PMAX. An inc while pend_cnt==PMAX sets overflow=1 and drops the event.
- clear=1:
  - Next edge sets pend_cnt=0 and overflow=0; pulse_in in that cycle is ignored.
  - An in-progress HIGH/GAP is not cut short; the block completes it, then goes to IDLE.
- Timer:
  - Counts down and never wraps.
  - Reloaded only on state entry.
- Reset asserted mid-pulse: led_out drops immediately; pending events are lost.

Test Plan (defaults: WIDTH_CYC=16, GAP_CYC=8, PEND_W=3):
1. Release rst; single pulse_in at edge 10 -> led_out=1 after edges 10..25 (16 cycles), 0 for 8 cycles, busy 1 for 24 cycles then 0, pend_cnt stays 0.
2. Three strobes during first HIGH -> pend_cnt=3; four 16-cycle pulses separated by exactly 8 low cycles; pend_cnt steps 3,2,1,0 at each GAP exit; overflow=0.
3. Nine strobes during first HIGH -> pend_cnt saturates at 7; overflow=1 after 8th queued strobe; exactly 8 pulses total emitted.
4. Strobe only in final GAP cycle, pend_cnt=0 -> next HIGH starts on following edge; low gap measures exactly 8; pend_cnt stays 0.
5. pend_cnt=2 and overflow=1, then clear pulsed mid-HIGH together with pulse_in -> pend_cnt=0, overflow=0, current pulse completes 16 high + 8 low, then IDLE, no extra pulses.
6. rst dropped mid-HIGH between clock edges -> led_out, busy, pend_cnt, overflow all 0 before next edge; after release, one strobe yields a normal 16-cycle pulse.
